// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci sequencer slice.
package fib_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fib_state_t;

  localparam int FIB_WIDTH_DEF = 17;
  localparam int FIB_NW_DEF    = 5;

endpackage

// File: rtl/fib_core.sv
// Fibonacci stepping datapath: load sets ant/ant2 to 1, step advances one term.
// Optional per-register overflow tracking when FIB_OVF_DETECT_EN is defined.
module fib_core
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] ant2,
  output logic             ant2_ovf
);

  logic [WIDTH-1:0] ant_q, ant_d;
  logic [WIDTH-1:0] ant2_q, ant2_d;

`ifdef FIB_OVF_DETECT_EN
  logic             ant_ovf_q, ant_ovf_d;
  logic             ant2_ovf_q, ant2_ovf_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum        = {1'b0, ant_q} + {1'b0, ant2_q};
    ant_d      = ant_q;
    ant2_d     = ant2_q;
    ant_ovf_d  = ant_ovf_q;
    ant2_ovf_d = ant2_ovf_q;
    if (load) begin
      ant_d      = WIDTH'(1);
      ant2_d     = WIDTH'(1);
      ant_ovf_d  = 1'b0;
      ant2_ovf_d = 1'b0;
    end else if (step) begin
      ant_d      = sum[WIDTH-1:0];
      ant2_d     = ant_q;
      // ant runs one term ahead, so its flag only reaches ant2 once that term is the result
      ant_ovf_d  = sum[WIDTH] | ant_ovf_q | ant2_ovf_q;
      ant2_ovf_d = ant_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ant_ovf_q  <= 1'b0;
      ant2_ovf_q <= 1'b0;
    end else begin
      ant_ovf_q  <= ant_ovf_d;
      ant2_ovf_q <= ant2_ovf_d;
    end
  end

  assign ant2_ovf = ant2_ovf_q;
`else
  always_comb begin
    ant_d  = ant_q;
    ant2_d = ant2_q;
    if (load) begin
      ant_d  = WIDTH'(1);
      ant2_d = WIDTH'(1);
    end else if (step) begin
      ant_d  = ant_q + ant2_q;
      ant2_d = ant_q;
    end
  end

  assign ant2_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ant_q  <= '0;
      ant2_q <= '0;
    end else begin
      ant_q  <= ant_d;
      ant2_q <= ant2_d;
    end
  end

  assign ant2 = ant2_q;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Request/response controller sequencing fib_core to return F(n) mod 2^WIDTH.
// Define FIB_OVF_DETECT_EN to report results that exceeded WIDTH bits on resp_ovf.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int NW    = FIB_NW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [NW-1:0]    req_n,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_ovf,
  input  logic             resp_ready,
  output logic             busy
);

  fib_state_t       state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             small_q, small_d;
  logic             small_val_q, small_val_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_ant2;
  logic             core_ant2_ovf;

  fib_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .step     (core_step),
    .ant2     (core_ant2),
    .ant2_ovf (core_ant2_ovf)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    small_d     = small_q;
    small_val_d = small_val_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_n < NW'(2)) begin
            // n<=1 bypasses the datapath with a forced result
            small_d     = 1'b1;
            small_val_d = req_n[0];
            state_d     = DONE;
          end else begin
            small_d   = 1'b0;
            core_load = 1'b1;
            cnt_d     = req_n - NW'(1);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - NW'(1);
        if (cnt_q == NW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      small_q      <= 1'b0;
      small_val_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      small_q      <= small_d;
      small_val_q  <= small_val_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign resp_data  = resp_valid_q ? (small_q ? WIDTH'(small_val_q) : core_ant2) : '0;
  assign resp_ovf   = resp_valid_q && !small_q && core_ant2_ovf;

endmodule
